// File: rtl/btn_pkg.sv
// btn_pkg: shared state type and counter width helpers for the button conditioner
package btn_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int hold_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: raw button pins in, conditioned level and pulses out
interface btn_conditioner_if #(parameter int N = 2);
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_long;
  modport master(output btn_raw, input btn_level, btn_press, btn_release, btn_long);
  modport slave(input btn_raw, output btn_level, btn_press, btn_release, btn_long);
endinterface

// File: rtl/btn_conditioner_channel.sv
// btn_channel: synchronizer, debounce FSM and hold timer for one button
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_p
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam int HW = hold_w(LONG_CYCLES);
  localparam logic [CW-1:0] C_END = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [HW-1:0] H_END = HW'(LONG_CYCLES - 2);
  localparam logic [HW-1:0] H_MAX = HW'(LONG_CYCLES - 1);
  localparam logic IDLE_LVL = (BTN_ACTIVE_LOW != 0);
  btn_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic s1_q, s2_q, p;
  logic long_done_q, long_done_d;
  logic level_q, level_d, press_q, press_d, rel_q, rel_d, long_q, long_d;
  assign p = s2_q ^ IDLE_LVL;
  // counters compare against END-1 so the transition lands on the edge the count reaches END
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    hold_d      = (hold_q == H_MAX) ? hold_q : hold_q + 1'b1;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    rel_d       = 1'b0;
    long_d      = (state_q == HELD || state_q == RELEASE_WAIT) && hold_q == H_END && !long_done_q;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        cnt_d  = '0;
        if (p) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        hold_d = '0;
        if (!p) state_d = IDLE;
        else if (cnt_q == C_END) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
        end
      end
      HELD: begin
        cnt_d = '0;
        if (!p) state_d = RELEASE_WAIT;
      end
      default: begin
        if (p) state_d = HELD;
        else if (cnt_q == C_END) begin
          state_d = IDLE;
          level_d = 1'b0;
          rel_d   = 1'b1;
          long_d  = 1'b0;
        end
      end
    endcase
    long_done_d = rel_d ? 1'b0 : (long_done_q | long_d);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q        <= IDLE_LVL;
      s2_q        <= IDLE_LVL;
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      s1_q        <= raw;
      s2_q        <= s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      long_q      <= long_d;
    end
  end
  assign level  = level_q;
  assign press  = press_q;
  assign rel    = rel_q;
  assign long_p = long_q;
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: maps the button vectors onto independent conditioning channels
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input logic clk,
  input logic reset,
  btn_conditioner_if.slave bus
);
  logic [N_BTN-1:0] level, press, rel, lng;
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.btn_raw[i]),
      .level (level[i]),
      .press (press[i]),
      .rel   (rel[i]),
      .long_p(lng[i])
    );
  end
  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel;
  assign bus.btn_long    = lng;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed checks of debounce, pulse timing, glitch rejection and reset
module tb_btn_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  btn_conditioner_if #(.N(2)) bus ();
  btn_conditioner #(
    .N_BTN(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] ex(input logic [1:0] l, input logic [1:0] p, input logic [1:0] r, input logic [1:0] g);
    return {l, p, r, g};
  endfunction
  task automatic check(input string tag, input int k, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d: observed lvl/prs/rel/lng=%b expected %b", tag, k, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    bus.btn_raw = 2'b11;
    repeat (3) step();
    check("in_reset", 0, 8'h00);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("idle_after_reset", k, 8'h00);
    end
    bus.btn_raw = 2'b10;
    for (int k = 1; k <= 36; k++) begin
      step();
      check("press_hold_ch0", k, ex({1'b0, k >= 6}, {1'b0, k == 6}, 2'b00, {1'b0, k == 25}));
    end
    bus.btn_raw = 2'b11;
    step();
    step();
    bus.btn_raw = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("glitch_held", k, ex(2'b01, 2'b00, 2'b00, 2'b00));
    end
    bus.btn_raw = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("release_ch0", k, ex({1'b0, k < 6}, 2'b00, {1'b0, k == 6}, 2'b00));
    end
    for (int k = 1; k <= 12; k++) begin
      bus.btn_raw = (k % 2 == 1) ? 2'b10 : 2'b11;
      step();
      check("bounce", k, 8'h00);
    end
    bus.btn_raw = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("after_bounce", k, 8'h00);
    end
    bus.btn_raw = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      step();
      check("press_both", k, ex({2{k >= 6}}, {2{k == 6}}, 2'b00, 2'b00));
    end
    reset = 1'b1;
    #1;
    check("async_reset_clear", 0, 8'h00);
    step();
    step();
    check("held_in_reset", 0, 8'h00);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("repress_after_reset", k, ex({2{k >= 6}}, {2{k == 6}}, 2'b00, 2'b00));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream input stage for the VGA top: conditions the raw FPGA push-buttons (reset, swap and future ones) before they reach the application and painter logic.
- Per button, it does three things:
  - synchronizes the raw input to clk;
  - debounces it;
  - produces a clean level plus single-cycle press, release and long-press pulses.
- The pulses replace the inverted raw button wires currently feeding the application, so a swap press toggles exactly once.

Parameters:
- N_BTN, 2, number of independent button channels.
- DEBOUNCE_CYCLES, 500000, cycles the synchronized input must stay stable to accept a change (10 ms at 50 MHz); must be at least 2.
- LONG_CYCLES, 50000000, cycles of debounced hold before btn_long fires (1 s at 50 MHz); must be greater than DEBOUNCE_CYCLES.
- BTN_ACTIVE_LOW, 1, when 1 a raw level of 0 means pressed (board buttons); when 0 a raw level of 1 means pressed.

Ports:
- clk  in  1  system clock; clock of every flop in the block.
- reset  in  1  asynchronous, active-high reset.
- btn_raw  in  N_BTN  raw, asynchronous button pins.
- btn_level  out  N_BTN  debounced state, 1 = pressed.
- btn_press  out  N_BTN  one-cycle pulse on each accepted press.
- btn_release  out  N_BTN  one-cycle pulse on each accepted release.
- btn_long  out  N_BTN  one-cycle pulse, at most once per press, after LONG_CYCLES of hold.

Behaviour:
- Interface:
  - Single clock domain: clk.
  - reset is asynchronous and active-high.
  - All outputs are registered.
- Reset:
  - All outputs are 0.
  - Every FSM is in IDLE and every counter is 0.
  - Both sync flops load the released raw level (1 when BTN_ACTIVE_LOW=1), so a released button cannot cause a spurious press after reset.
- Synchronizer:
  - Two flops per channel: s1 <= btn_raw, then s2 <= s1.
  - p = s2 XOR BTN_ACTIVE_LOW; p=1 means pressed.
- Per-channel FSM states:
  - IDLE: level 0. If p=1, go to PRESS_WAIT and set cnt=0.
  - PRESS_WAIT: if p=0, return to IDLE (bounce rejected, no pulse). Otherwise cnt++. On the edge where cnt==DEBOUNCE_CYCLES-1: go to HELD, set level=1, pulse press, clear hold_cnt.
  - HELD:
    - hold_cnt increments and saturates at LONG_CYCLES-1.
    - On the edge where hold_cnt reaches LONG_CYCLES-1 and long_done=0: pulse long and set long_done.
    - If p=0, go to RELEASE_WAIT and set cnt=0.
  - RELEASE_WAIT:
    - Level stays 1 and hold_cnt keeps counting; long can still fire here.
    - If p=1, return to HELD (glitch rejected, no pulse).
    - On the edge where cnt==DEBOUNCE_CYCLES-1: go to IDLE, set level=0, pulse release, clear long_done.
- Latency: let t0 be the first clk edge at which btn_raw is sampled pressed and stays pressed.
  - btn_press and btn_level rise in the cycle after edge t0+DEBOUNCE_CYCLES+1.
  - btn_press is high for exactly 1 cycle.
  - Release timing is symmetric.
- Counter widths: cnt is clog2(DEBOUNCE_CYCLES) bits; hold_cnt is clog2(LONG_CYCLES) bits. Neither ever wraps.
- Channel independence: channels never interact. Simultaneous presses on several channels produce pulses in the same cycle.
- Pulse exclusivity: press, release and long are mutually exclusive within a channel in any cycle.
- Reset mid-press:
  - Outputs drop to 0 immediately.
  - If the button is still held when reset deasserts, a new full debounce runs and press fires again.

Decomposition:
- Package btn_pkg holds:
  - the typedef enum btn_state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT};
  - width helper functions for cnt and hold_cnt.
- Sub-module btn_channel holds the synchronizer, FSM and counters for one button.
  - It is instantiated N_BTN times via generate in btn_conditioner.
  - The top only maps the vectors onto the channels.

Test Plan (bench parameters: N_BTN=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, BTN_ACTIVE_LOW=1):
- Reset with btn_raw=2'b11 held for 10 cycles after deassert: all outputs stay 0 and no pulse appears.
- btn_raw[0] driven to 0 at edge t0 and held: btn_press[0] is high only in the cycle after t0+5, btn_level[0]=1 from then on, and channel 1 outputs stay 0.
- btn_raw[0] bounces 0,1,0,1 on alternating cycles for 12 cycles, then returns to 1: no press, no release, level stays 0.
- Channel 0 held 30 cycles past its press pulse:
  - exactly one btn_long[0] pulse, 19 cycles after the press pulse cycle;
  - after btn_raw goes back to 1, one btn_release[0] pulse 6 cycles later and level returns to 0.
- While channel 0 is HELD, btn_raw[0] glitches high for 2 cycles: no release pulse and level stays 1.
- Both channels pressed on the same edge, then reset asserted mid-hold and released while both are still held:
  - the two press pulses coincide;
  - reset clears all outputs;
  - after reset deasserts, a new press pulse fires on both channels 6 cycles later.
